ponylink_tx_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares one ponylink send stream (in_tdata/in_tuser/in_tvalid/in_tlast/in_tready of ponylink_master or ponylink_slave) between NUM_CH requester streams.
- Holds the grant for a whole packet (until tlast), so packets never interleave on the link.
- Starts new grants only while the link reports ready, and tags every beat with its source channel id.

---
 rtl/ponylink_tx_arbiter_pkg.sv | 16 +
 rtl/ponylink_rr_pick.sv | 43 ++++
 rtl/ponylink_tx_arbiter_chk.sv | 25 ++
 rtl/ponylink_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_ponylink_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ponylink_tx_arbiter_pkg.sv
// ponylink_tx_arbiter_pkg
// Shared types and helpers for the ponylink transmit arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE = 1'b0, BUSY = 1'b1)
//   wrap_add    : (base + off) modulo n, used for the round-robin scan order
package ponylink_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/ponylink_rr_pick.sv
// ponylink_rr_pick
// Combinational round-robin picker. Scans last_grant+1, last_grant+2, ...
// (wrapping modulo NUM_CH) and returns the first eligible channel.
// Ports:
//   eligible    in  [NUM_CH] channels allowed to win this round
//   last_grant  in  [CH_W]   channel that won most recently
//   found       out          at least one channel is eligible
//   pick_onehot out [NUM_CH] one-hot winner, zero when nothing found
//   pick_id     out [CH_W]   binary index of the winner, zero when nothing found
module ponylink_rr_pick
  import ponylink_tx_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   last_grant,
  output logic              found,
  output logic [NUM_CH-1:0] pick_onehot,
  output logic [CH_W-1:0]   pick_id
);

  // Walk the rotation starting just after the last winner; the first hit wins.
  always_comb begin
    found       = 1'b0;
    pick_id     = {CH_W{1'b0}};
    pick_onehot = {NUM_CH{1'b0}};
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!found && eligible[wrap_add(int'(last_grant), k, NUM_CH)]) begin
        found   = 1'b1;
        pick_id = CH_W'(wrap_add(int'(last_grant), k, NUM_CH));
      end else begin
        pick_id = pick_id;
      end
    end
    if (found) begin
      pick_onehot = NUM_CH'(1) << pick_id;
    end else begin
      pick_onehot = {NUM_CH{1'b0}};
    end
  end

endmodule

// File: rtl/ponylink_tx_arbiter_chk.sv
// ponylink_tx_arbiter_chk
// Invariant checker for ponylink_tx_arbiter, observing its ports only.
//   grant is one-hot or zero, and grant is nonzero exactly while busy.
// Ports:
//   clk, reset  clock and synchronous active-high reset of the arbiter
//   grant       arbiter grant vector
//   busy        arbiter busy flag
module ponylink_tx_arbiter_chk #(
  parameter int NUM_CH = 4
) (
  input logic              clk,
  input logic              reset,
  input logic [NUM_CH-1:0] grant,
  input logic              busy
);

  // Sample the grant invariants on every clock outside reset.
  always @(posedge clk) begin
    if (!reset) begin
      a_grant_onehot0: assert ($onehot0(grant));
      a_grant_iff_busy: assert ((grant != {NUM_CH{1'b0}}) == busy);
    end
  end

endmodule

// File: rtl/ponylink_tx_arbiter.sv
// ponylink_tx_arbiter
// Packet-locked round-robin arbiter sharing one ponylink send stream between
// NUM_CH requester streams. A grant is held from the first beat through tlast,
// new grants only start while linkready is high, and each beat carries the
// id of its source channel.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   linkready          link-up status, gates new grants only
//   ch_enable          per-channel enable mask
//   req_tdata/tuser    packed requester payloads, channel i at [i*W +: W]
//   req_tvalid/tlast   per-channel valid / end-of-packet
//   req_tready         per-channel ready (only the granted channel sees out_tready)
//   out_tdata/tuser    to link in_tdata / in_tuser
//   out_tvalid/tlast   to link in_tvalid / in_tlast
//   out_tready         from link in_tready
//   out_tid            source channel of the current beat
//   grant              one-hot current grant, zero while idle
//   busy               a packet is in flight
module ponylink_tx_arbiter
  import ponylink_tx_arbiter_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int TDATA_WIDTH = 8,
  parameter  int TUSER_WIDTH = 4,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          linkready,
  input  logic [NUM_CH-1:0]             ch_enable,
  input  logic [NUM_CH*TDATA_WIDTH-1:0] req_tdata,
  input  logic [NUM_CH*TUSER_WIDTH-1:0] req_tuser,
  input  logic [NUM_CH-1:0]             req_tvalid,
  input  logic [NUM_CH-1:0]             req_tlast,
  output logic [NUM_CH-1:0]             req_tready,
  output logic [TDATA_WIDTH-1:0]        out_tdata,
  output logic [TUSER_WIDTH-1:0]        out_tuser,
  output logic                          out_tvalid,
  output logic                          out_tlast,
  input  logic                          out_tready,
  output logic [CH_W-1:0]               out_tid,
  output logic [NUM_CH-1:0]             grant,
  output logic                          busy
);

  arb_state_e          state_r;
  logic [NUM_CH-1:0]   grant_r;
  logic [CH_W-1:0]     last_grant_r;
  logic [CH_W-1:0]     tid_r;

  logic [NUM_CH-1:0]   eligible_s;
  logic                found_s;
  logic [NUM_CH-1:0]   pick_onehot_s;
  logic [CH_W-1:0]     pick_id_s;
  logic                hs_last_s;

  assign eligible_s = req_tvalid & ch_enable;

  ponylink_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .eligible    (eligible_s),
    .last_grant  (last_grant_r),
    .found       (found_s),
    .pick_onehot (pick_onehot_s),
    .pick_id     (pick_id_s)
  );

  // Forward the granted channel to the link; everything is quiet while idle.
  always_comb begin
    out_tdata  = {TDATA_WIDTH{1'b0}};
    out_tuser  = {TUSER_WIDTH{1'b0}};
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    req_tready = {NUM_CH{1'b0}};
    if (state_r == ST_BUSY) begin
      out_tdata  = req_tdata[tid_r*TDATA_WIDTH +: TDATA_WIDTH];
      out_tuser  = req_tuser[tid_r*TUSER_WIDTH +: TUSER_WIDTH];
      out_tvalid = req_tvalid[tid_r];
      out_tlast  = req_tlast[tid_r];
      // grant_r is one-hot here, so only the owner sees the link's ready
      req_tready = grant_r & {NUM_CH{out_tready}};
    end else begin
      out_tvalid = 1'b0;
    end
  end

  assign hs_last_s = out_tvalid & out_tready & out_tlast;

  // Arbiter FSM: grant on IDLE->BUSY, release after the tlast handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= {NUM_CH{1'b0}};
      // last winner = NUM_CH-1 makes channel 0 first in the scan
      last_grant_r <= CH_W'(NUM_CH - 1);
      tid_r        <= {CH_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (linkready && found_s) begin
            grant_r      <= pick_onehot_s;
            last_grant_r <= pick_id_s;
            tid_r        <= pick_id_s;
            state_r      <= ST_BUSY;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // linkready and ch_enable are deliberately ignored mid-packet
          if (hs_last_s) begin
            grant_r <= {NUM_CH{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          grant_r <= {NUM_CH{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant   = grant_r;
  assign out_tid = tid_r;
  assign busy    = (state_r == ST_BUSY);

endmodule

// File: tb/tb_ponylink_tx_arbiter.sv
// tb_ponylink_tx_arbiter
// Scoreboard bench: every beat handed to a requester queue is also pushed
// (in the order the arbiter should serve it) to an expected queue; each
// link handshake pops and compares. Grant order is logged and compared too.
module tb_ponylink_tx_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int UW     = 4;
  localparam int CW     = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 linkready;
  logic [NUM_CH-1:0]    ch_enable;
  logic [NUM_CH*DW-1:0] req_tdata;
  logic [NUM_CH*UW-1:0] req_tuser;
  logic [NUM_CH-1:0]    req_tvalid;
  logic [NUM_CH-1:0]    req_tlast;
  logic [NUM_CH-1:0]    req_tready;
  logic [DW-1:0]        out_tdata;
  logic [UW-1:0]        out_tuser;
  logic                 out_tvalid;
  logic                 out_tlast;
  logic                 out_tready;
  logic [CW-1:0]        out_tid;
  logic [NUM_CH-1:0]    grant;
  logic                 busy;

  always #5 clk = ~clk;

  ponylink_tx_arbiter #(
    .NUM_CH      (NUM_CH),
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (UW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .linkready  (linkready),
    .ch_enable  (ch_enable),
    .req_tdata  (req_tdata),
    .req_tuser  (req_tuser),
    .req_tvalid (req_tvalid),
    .req_tlast  (req_tlast),
    .req_tready (req_tready),
    .out_tdata  (out_tdata),
    .out_tuser  (out_tuser),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready),
    .out_tid    (out_tid),
    .grant      (grant),
    .busy       (busy)
  );

  ponylink_tx_arbiter_chk #(.NUM_CH(NUM_CH)) u_chk (
    .clk   (clk),
    .reset (reset),
    .grant (grant),
    .busy  (busy)
  );

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t             src_q [NUM_CH][$];
  beat_t             exp_q [$];
  logic [NUM_CH-1:0] gnt_log [$];

  int                n_checks = 0;
  int                n_fail   = 0;
  int                hs_count = 0;
  int                cyc      = 0;
  int                last_end_cyc = 0;
  bit                end_valid  = 1'b0;
  bit                first_beat = 1'b1;
  bit                gap_chk_en = 1'b0;
  logic [NUM_CH-1:0] prev_grant = '0;
  logic [NUM_CH-1:0] hs_ch      = '0;
  logic [NUM_CH-1:0] src_stall  = '0;
  logic [7:0]        seq        = 8'h40;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NUM_CH; i++) begin
      if (src_q[i].size() > 0 && !src_stall[i]) begin
        req_tvalid[i]          = 1'b1;
        req_tdata[i*DW +: DW]  = src_q[i][0].data;
        req_tuser[i*UW +: UW]  = src_q[i][0].user;
        req_tlast[i]           = src_q[i][0].last;
      end else begin
        req_tvalid[i] = 1'b0;
        req_tlast[i]  = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    hs_ch = req_tvalid & req_tready;
    if (grant != prev_grant && grant != '0) gnt_log.push_back(grant);
    prev_grant = grant;
    if (out_tvalid && out_tready) begin
      hs_count++;
      check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 32'({out_tid, out_tdata, out_tuser, out_tlast}), 32'(e));
      end
      if (gap_chk_en && first_beat && end_valid) check("pkt_gap", 32'(cyc - last_end_cyc), 32'd2);
      first_beat = out_tlast;
      if (out_tlast) begin
        last_end_cyc = cyc;
        end_valid    = 1'b1;
      end
    end
    cyc++;
  endtask

  // Sample at negedge, then advance sources past the following posedge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hs_ch[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive_src();
    #1;
  endtask

  task automatic push_beat(input int ch, input logic [7:0] data, input bit last, input bit to_exp);
    beat_t b;
    b.ch   = CW'(ch);
    b.data = data;
    b.user = data[7:4] ^ data[3:0];
    b.last = last;
    src_q[ch].push_back(b);
    if (to_exp) exp_q.push_back(b);
  endtask

  task automatic send_pkt(input int ch, input int n, input bit to_exp);
    for (int k = 0; k < n; k++) begin
      push_beat(ch, seq, (k == n - 1), to_exp);
      seq = seq + 8'd1;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
    exp_q.delete();
    gnt_log.delete();
    src_stall = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_all();
    drive_src();
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_req_tready", 32'(req_tready), 32'd0);
    check("rst_out_tid", 32'(out_tid), 32'd0);
    reset      = 1'b0;
    prev_grant = '0;
    end_valid  = 1'b0;
    first_beat = 1'b1;
    gap_chk_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] gnt_order();
    logic [31:0] v = '0;
    foreach (gnt_log[i]) v = (v << 4) | 32'(gnt_log[i]);
    return v;
  endfunction

  initial begin
    int h0;
    bit pat [4];
    reset      = 1'b1;
    linkready  = 1'b1;
    out_tready = 1'b1;
    ch_enable  = 4'hF;
    req_tdata  = '0;
    req_tuser  = '0;
    req_tvalid = '0;
    req_tlast  = '0;

    // 1: single 3-beat packet on ch0
    reset_dut();
    push_beat(0, 8'h11, 1'b0, 1'b1);
    push_beat(0, 8'h22, 1'b0, 1'b1);
    push_beat(0, 8'h33, 1'b1, 1'b1);
    drive_src();
    #1;
    check("t1_bubble", 32'(out_tvalid), 32'd0);
    tick();
    check("t1_tvalid_rise", 32'(out_tvalid), 32'd1);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_tid", 32'(out_tid), 32'd0);
    check("t1_data0", 32'(out_tdata), 32'h11);
    h0 = hs_count;
    tick();
    tick();
    tick();
    check("t1_consecutive", 32'(hs_count - h0), 32'd3);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_all_beats", 32'(exp_q.size()), 32'd0);

    // 2: all channels continuously requesting 2-beat packets
    reset_dut();
    gap_chk_en = 1'b1;
    send_pkt(0, 2, 1'b1);
    send_pkt(1, 2, 1'b1);
    send_pkt(2, 2, 1'b1);
    send_pkt(3, 2, 1'b1);
    send_pkt(0, 2, 1'b1);
    drive_src();
    drain("t2_drain", 100);
    check("t2_order", gnt_order(), 32'h0001_2481);
    gap_chk_en = 1'b0;

    // 3: backpressure mid-packet on ch2
    reset_dut();
    send_pkt(2, 4, 1'b1);
    drive_src();
    tick();
    check("t3_tid", 32'(out_tid), 32'd2);
    h0 = hs_count;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      out_tready = pat[s];
      #1;
      check("t3_rdy_mirror", 32'(req_tready), pat[s] ? 32'h4 : 32'h0);
      tick();
    end
    out_tready = 1'b1;
    drain("t3_drain", 20);
    check("t3_beat_count", 32'(hs_count - h0), 32'd4);

    // 4: linkready gating of new grants only
    reset_dut();
    linkready = 1'b0;
    send_pkt(1, 3, 1'b1);
    drive_src();
    for (int s = 0; s < 10; s++) begin
      tick();
      check("t4_held_idle", 32'({grant, out_tvalid}), 32'd0);
    end
    linkready = 1'b1;
    tick();
    check("t4_grant", 32'(grant), 32'h2);
    tick();
    linkready = 1'b0;
    drain("t4_completes", 20);
    check("t4_busy_after", 32'(busy), 32'd0);
    linkready = 1'b1;

    // 5: channel 2 disabled while everyone is valid
    reset_dut();
    ch_enable = 4'b1011;
    send_pkt(0, 2, 1'b1);
    send_pkt(1, 2, 1'b1);
    send_pkt(2, 2, 1'b0);
    send_pkt(3, 2, 1'b1);
    send_pkt(0, 2, 1'b1);
    drive_src();
    drain("t5_drain", 100);
    check("t5_order", gnt_order(), 32'h0000_1281);
    ch_enable = 4'hF;

    // 6: reset during beat 2 of a ch3 packet
    reset_dut();
    send_pkt(3, 4, 1'b1);
    drive_src();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t6_grant_cleared", 32'(grant), 32'd0);
    check("t6_tvalid_low", 32'(out_tvalid), 32'd0);
    check("t6_busy_low", 32'(busy), 32'd0);
    clear_all();
    reset      = 1'b0;
    prev_grant = '0;
    first_beat = 1'b1;
    send_pkt(0, 2, 1'b1);
    send_pkt(3, 2, 1'b1);
    drive_src();
    drain("t6_drain", 40);
    check("t6_order", gnt_order(), 32'h0000_0018);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
